seq_adder: RTL and testbench

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/seq_adder_if.sv | 24 ++
 rtl/seq_adder.sv | 95 +++++++++
 tb/tb_seq_adder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_adder_if.sv
// rtl/seq_adder_if.sv - request/result bundle for the sequential adder
interface seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_adder.sv
// rtl/seq_adder.sv - multi-cycle adder processing STEP bits per clock
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_adder_if.slave  bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [STEP-1:0]  a_sl, b_sl;
  logic [STEP:0]    slice_res;
  logic             last_slice, msb_cin;

  always_comb begin
    a_sl  = '0;
    b_sl  = '0;
    acc_d = acc_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl = a_q[i*STEP +: STEP];
        b_sl = b_q[i*STEP +: STEP];
      end
    end
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{STEP{1'b0}}, carry_q};
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) acc_d[i*STEP +: STEP] = slice_res[STEP-1:0];
    end
    last_slice = (cnt_q == CW'(N - 1));
    // carry into the MSB recovered from the MSB sum bit of the final slice
    msb_cin = slice_res[STEP-1] ^ a_sl[STEP-1] ^ b_sl[STEP-1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= slice_res[STEP];
          cnt_q   <= cnt_q + CW'(1);
          if (last_slice) begin
            sum_q  <= acc_d;
            cout_q <= slice_res[STEP];
            ovf_q  <= msb_cin ^ slice_res[STEP];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_adder.sv
// tb/tb_seq_adder.sv - directed self-checking bench for seq_adder
module tb_seq_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_adder_if #(.WIDTH(16)) m16 ();
  seq_adder_if #(.WIDTH(4))  m41 ();
  seq_adder_if #(.WIDTH(4))  m44 ();

  seq_adder #(.WIDTH(16), .STEP(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(m16));
  seq_adder #(.WIDTH(4),  .STEP(1)) u41 (.clk(clk), .rst_n(rst_n), .bus(m41));
  seq_adder #(.WIDTH(4),  .STEP(4)) u44 (.clk(clk), .rst_n(rst_n), .bus(m44));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, output bit ok);
    m16.a = a; m16.b = b; m16.cin = cin; m16.start = 1'b1;
    tick;
    m16.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick;
      if (m16.done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst_n = 1'b0;
    m16.start = 1'b1; m16.a = 16'h1234; m16.b = 16'h0001; m16.cin = 1'b0;
    tick; tick;
    checks++; if (m16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", m16.busy); end
    checks++; if (m16.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", m16.done); end
    checks++; if (m16.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", m16.sum); end
    checks++; if ({m16.cout, m16.ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {m16.cout, m16.ovf}); end
    checks++; if ({m41.busy, m44.busy, m41.sum, m44.sum} !== 10'h0) begin errors++; $display("FAIL reset_small got=%h exp=0", {m41.busy, m44.busy, m41.sum, m44.sum}); end
    rst_n = 1'b1;
    tick;
    checks++; if (m16.busy !== 1'b1) begin errors++; $display("FAIL first_accept busy got=%b exp=1", m16.busy); end
    m16.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick;
      if (m16.done === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok || m16.sum !== 16'h1235) begin errors++; $display("FAIL first_accept sum got=%h done=%b exp=1235", m16.sum, ok); end
    tick;
  endtask

  task automatic test_basic;
    m16.a = 16'h00FF; m16.b = 16'h0001; m16.cin = 1'b0; m16.start = 1'b1;
    tick;
    m16.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({m16.busy, m16.done} !== 2'b10) begin errors++; $display("FAIL basic_busy cycle=%0d got=%b exp=10", i + 1, {m16.busy, m16.done}); end
      tick;
    end
    checks++; if ({m16.busy, m16.done} !== 2'b01) begin errors++; $display("FAIL basic_done got=%b exp=01", {m16.busy, m16.done}); end
    checks++; if ({m16.cout, m16.ovf, m16.sum} !== {2'b00, 16'h0100}) begin errors++; $display("FAIL basic_result got=%b%b_%h exp=00_0100", m16.cout, m16.ovf, m16.sum); end
    tick;
    checks++; if ({m16.busy, m16.done} !== 2'b00) begin errors++; $display("FAIL basic_idle got=%b exp=00", {m16.busy, m16.done}); end
  endtask

  task automatic test_arith;
    logic [15:0] va [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'h8000};
    logic [15:0] vb [5] = '{16'h0001, 16'h0000, 16'h8000, 16'h4321, 16'hFFFF};
    logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] es [5] = '{16'h0000, 16'h8000, 16'h0000, 16'h5556, 16'h7FFF};
    logic [1:0]  ef [5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b11};
    bit ok;
    for (int i = 0; i < 5; i++) begin
      op16(va[i], vb[i], vc[i], ok);
      checks++;
      if (!ok || m16.sum !== es[i] || {m16.cout, m16.ovf} !== ef[i]) begin
        errors++;
        $display("FAIL arith_%0d got sum=%h cout_ovf=%b done=%b exp sum=%h cout_ovf=%b", i, m16.sum, {m16.cout, m16.ovf}, ok, es[i], ef[i]);
      end
      tick;
    end
  endtask

  task automatic test_ignore;
    int dones = 0;
    m16.a = 16'h1234; m16.b = 16'h1111; m16.cin = 1'b0; m16.start = 1'b1;
    tick;
    m16.a = 16'hFFFF; m16.b = 16'hFFFF; m16.cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (m16.done === 1'b1) dones++;
    end
    m16.start = 1'b0;
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (m16.sum !== 16'h2345) begin errors++; $display("FAIL ignore_sum got=%h exp=2345", m16.sum); end
    tick;
    checks++; if (m16.done !== 1'b0) begin errors++; $display("FAIL ignore_pulse_width got=%b exp=0", m16.done); end
    m16.a = 16'h0001; m16.b = 16'h0001; m16.cin = 1'b0; m16.start = 1'b1;
    tick;
    m16.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m16.sum !== 16'h2345) begin errors++; $display("FAIL hold_sum cycle=%0d got=%h exp=2345", i, m16.sum); end
      tick;
    end
    checks++; if ({m16.done, m16.sum} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL hold_next got=%b_%h exp=1_0002", m16.done, m16.sum); end
    tick;
  endtask

  task automatic test_reset_mid;
    int  dones = 0;
    bit  ok;
    m16.a = 16'h00FF; m16.b = 16'h0001; m16.cin = 1'b0; m16.start = 1'b1;
    tick;
    m16.start = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++; if ({m16.busy, m16.done} !== 2'b00) begin errors++; $display("FAIL abort_state got=%b exp=00", {m16.busy, m16.done}); end
    checks++; if (m16.sum !== 16'h0000) begin errors++; $display("FAIL abort_sum got=%h exp=0000", m16.sum); end
    for (int i = 0; i < 8; i++) begin
      tick;
      if (m16.done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    op16(16'h00FF, 16'h0001, 1'b0, ok);
    checks++; if (!ok || m16.sum !== 16'h0100) begin errors++; $display("FAIL abort_recover got=%h done=%b exp=0100", m16.sum, ok); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [3] = '{16'h0001, 16'hABCD, 16'hFFFF};
    logic [15:0] vb [3] = '{16'h0002, 16'h1111, 16'hFFFF};
    logic        vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [16:0] er [3] = '{17'h00003, 17'h0BCDF, 17'h1FFFF};
    int dcyc [3];
    int k = 0;
    m16.a = va[0]; m16.b = vb[0]; m16.cin = vc[0]; m16.start = 1'b1;
    tick;
    m16.a = 16'h5555; m16.b = 16'h5555; m16.cin = 1'b0;
    for (int c = 1; c < 40 && k < 3; c++) begin
      tick;
      if (m16.done === 1'b1) begin
        dcyc[k] = c;
        checks++;
        if ({m16.cout, m16.sum} !== er[k]) begin errors++; $display("FAIL b2b_result_%0d got=%h exp=%h", k, {m16.cout, m16.sum}, er[k]); end
        k++;
        if (k < 3) begin m16.a = va[k]; m16.b = vb[k]; m16.cin = vc[k]; end
        else m16.start = 1'b0;
      end
    end
    m16.start = 1'b0;
    checks++; if (k != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", k); end
    if (k == 3) begin
      checks++; if (dcyc[1] - dcyc[0] != 6 || dcyc[2] - dcyc[1] != 6) begin errors++; $display("FAIL b2b_spacing got=%0d,%0d exp=6,6", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]); end
    end
    tick; tick;
  endtask

  task automatic test_exhaustive;
    logic [4:0] exp_r;
    logic       exp_o;
    logic [4:0] r41, r44;
    logic       o41, o44;
    bit         g41, g44;
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      m41.a = vv[7:4]; m41.b = vv[3:0]; m41.cin = vv[8];
      m44.a = vv[7:4]; m44.b = vv[3:0]; m44.cin = vv[8];
      m41.start = 1'b1; m44.start = 1'b1;
      exp_r = {1'b0, vv[7:4]} + {1'b0, vv[3:0]} + {4'b0, vv[8]};
      exp_o = (vv[7] == vv[3]) && (exp_r[3] != vv[7]);
      tick;
      m41.start = 1'b0; m44.start = 1'b0;
      g41 = 1'b0; g44 = 1'b0;
      r41 = '0; r44 = '0; o41 = 1'b0; o44 = 1'b0;
      for (int i = 0; i < 10 && !(g41 && g44); i++) begin
        tick;
        if (m41.done === 1'b1) begin g41 = 1'b1; r41 = {m41.cout, m41.sum}; o41 = m41.ovf; end
        if (m44.done === 1'b1) begin g44 = 1'b1; r44 = {m44.cout, m44.sum}; o44 = m44.ovf; end
      end
      tick;
      checks++;
      if (!g41 || r41 !== exp_r || o41 !== exp_o) begin errors++; $display("FAIL exh_step1 v=%h got=%h ovf=%b done=%b exp=%h ovf=%b", v, r41, o41, g41, exp_r, exp_o); end
      checks++;
      if (!g44 || r44 !== exp_r || o44 !== exp_o) begin errors++; $display("FAIL exh_step4 v=%h got=%h ovf=%b done=%b exp=%h ovf=%b", v, r44, o44, g44, exp_r, exp_o); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m16.start = 1'b0; m16.a = '0; m16.b = '0; m16.cin = 1'b0;
    m41.start = 1'b0; m41.a = '0; m41.b = '0; m41.cin = 1'b0;
    m44.start = 1'b0; m44.a = '0; m44.b = '0; m44.cin = 1'b0;
    test_reset;
    test_basic;
    test_arith;
    test_ignore;
    test_reset_mid;
    test_back_to_back;
    test_exhaustive;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
